// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch stage.
// Owns the fetch PC, issues in-order requests to instruction memory over a
// valid/ready handshake, and buffers returned instructions in a DEPTH-entry
// FIFO toward decode. A redirect flushes the FIFO and marks every request
// still in flight as stale so its response is discarded on arrival.
// Slots are reserved at issue time (FIFO occupancy + outstanding <= DEPTH),
// so a response never finds the FIFO full.
//
// Optional feature macro: FETCH_ACCESS_FAULT_EN
//   defined   - a live response with imem_resp_err=1 is stored with fault=1
//               and instr=0, and issue halts until the next redirect.
//   undefined - imem_resp_err is ignored and fetch_o_fault is tied to 0.
module fetch_queue #(
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [XLEN-1:0]          imem_req_addr,
    input  logic                     imem_resp_valid,
    input  logic [ILEN-1:0]          imem_resp_data,
    input  logic                     imem_resp_err,
    output logic                     fetch_o_valid,
    input  logic                     fetch_i_ready,
    output logic [XLEN+ILEN-1:0]     fetch_o_bus_info,
    output logic [ILEN+2*XLEN:0]     fetch_o_commit_info,
    output logic                     fetch_o_fault
);

    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1'b1);
    localparam logic [PW-1:0]   PTR_ONE = PW'(1'b1);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

    // Architectural state
    logic [XLEN-1:0] r_req_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;

    // FIFO storage
    logic [XLEN-1:0] r_pc_mem    [DEPTH];
    logic [ILEN-1:0] r_instr_mem [DEPTH];

    // Next-state values
    logic [XLEN-1:0] w_req_pc_nxt;
    logic [XLEN-1:0] w_resp_pc_nxt;
    logic [CW-1:0]   w_count_nxt;
    logic [CW-1:0]   w_out_nxt;
    logic [CW-1:0]   w_drop_nxt;
    logic [PW-1:0]   w_wr_ptr_nxt;
    logic [PW-1:0]   w_rd_ptr_nxt;

    // Handshake and datapath helpers
    logic [CW:0]     w_occupancy;
    logic            w_halted;
    logic            w_req_fire;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_issue_inc;
    logic [CW-1:0]   w_resp_dec;
    logic [CW-1:0]   w_push_inc;
    logic [CW-1:0]   w_pop_dec;
    logic [ILEN-1:0] w_push_instr;
    logic [XLEN-1:0] w_head_pc;
    logic [ILEN-1:0] w_head_instr;

`ifdef FETCH_ACCESS_FAULT_EN
    logic            r_halted;
    logic            w_halted_nxt;
    logic            r_fault_mem [DEPTH];

    assign w_halted     = r_halted;
    assign w_push_instr = imem_resp_err ? {ILEN{1'b0}} : imem_resp_data;
`else
    logic            w_unused;

    assign w_halted     = 1'b0;
    assign w_push_instr = imem_resp_data;
    assign w_unused     = imem_resp_err;
`endif

    assign w_occupancy    = {1'b0, r_count} + {1'b0, r_outstanding};
    assign imem_req_valid = !rst && !redirect_valid && !w_halted &&
                            (w_occupancy < {1'b0, DEPTH_C});
    assign imem_req_addr  = r_req_pc;

    assign w_req_fire = imem_req_valid && imem_req_ready;
    // Responses are live only when no stale requests remain ahead of them
    // and no redirect is discarding them this cycle.
    assign w_push     = imem_resp_valid && !redirect_valid && (r_drop == {CW{1'b0}});
    assign w_pop      = fetch_o_valid && fetch_i_ready;

    assign w_issue_inc = w_req_fire      ? CNT_ONE : {CW{1'b0}};
    assign w_resp_dec  = imem_resp_valid ? CNT_ONE : {CW{1'b0}};
    assign w_push_inc  = w_push          ? CNT_ONE : {CW{1'b0}};
    assign w_pop_dec   = w_pop           ? CNT_ONE : {CW{1'b0}};

    // Compute next values of PCs, counters and FIFO pointers; redirect wins.
    always_comb begin
        w_req_pc_nxt  = r_req_pc;
        w_resp_pc_nxt = r_resp_pc;
        w_count_nxt   = r_count;
        w_out_nxt     = r_outstanding;
        w_drop_nxt    = r_drop;
        w_wr_ptr_nxt  = r_wr_ptr;
        w_rd_ptr_nxt  = r_rd_ptr;
`ifdef FETCH_ACCESS_FAULT_EN
        w_halted_nxt  = r_halted;
`endif
        if (redirect_valid) begin
            w_req_pc_nxt  = redirect_pc;
            w_resp_pc_nxt = redirect_pc;
            w_count_nxt   = {CW{1'b0}};
            w_wr_ptr_nxt  = {PW{1'b0}};
            w_rd_ptr_nxt  = {PW{1'b0}};
            // Outstanding already counts stale requests too, so after a
            // redirect every request still in flight is stale: the drop
            // count becomes exactly the in-flight count after this cycle.
            w_out_nxt     = r_outstanding - w_resp_dec;
            w_drop_nxt    = r_outstanding - w_resp_dec;
`ifdef FETCH_ACCESS_FAULT_EN
            w_halted_nxt  = 1'b0;
`endif
        end else begin
            if (w_req_fire) begin
                w_req_pc_nxt = r_req_pc + PC_STEP;
            end else begin
                w_req_pc_nxt = r_req_pc;
            end
            w_out_nxt = r_outstanding + w_issue_inc - w_resp_dec;
            if (imem_resp_valid && (r_drop != {CW{1'b0}})) begin
                w_drop_nxt = r_drop - CNT_ONE;
            end else begin
                w_drop_nxt = r_drop;
            end
            if (w_push) begin
                w_resp_pc_nxt = r_resp_pc + PC_STEP;
                w_wr_ptr_nxt  = r_wr_ptr + PTR_ONE;
            end else begin
                w_resp_pc_nxt = r_resp_pc;
                w_wr_ptr_nxt  = r_wr_ptr;
            end
            if (w_pop) begin
                w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
            end else begin
                w_rd_ptr_nxt = r_rd_ptr;
            end
            w_count_nxt = r_count + w_push_inc - w_pop_dec;
`ifdef FETCH_ACCESS_FAULT_EN
            if (w_push && imem_resp_err) begin
                w_halted_nxt = 1'b1;
            end else begin
                w_halted_nxt = r_halted;
            end
`endif
        end
    end

    // Register control state; synchronous reset restarts fetch at RESET_PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_pc      <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_count       <= {CW{1'b0}};
            r_outstanding <= {CW{1'b0}};
            r_drop        <= {CW{1'b0}};
            r_wr_ptr      <= {PW{1'b0}};
            r_rd_ptr      <= {PW{1'b0}};
`ifdef FETCH_ACCESS_FAULT_EN
            r_halted      <= 1'b0;
`endif
        end else begin
            r_req_pc      <= w_req_pc_nxt;
            r_resp_pc     <= w_resp_pc_nxt;
            r_count       <= w_count_nxt;
            r_outstanding <= w_out_nxt;
            r_drop        <= w_drop_nxt;
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_rd_ptr      <= w_rd_ptr_nxt;
`ifdef FETCH_ACCESS_FAULT_EN
            r_halted      <= w_halted_nxt;
`endif
        end
    end

    // Write live responses into the FIFO slot at the write pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]    <= {XLEN{1'b0}};
                r_instr_mem[i] <= {ILEN{1'b0}};
`ifdef FETCH_ACCESS_FAULT_EN
                r_fault_mem[i] <= 1'b0;
`endif
            end
        end else if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= r_resp_pc;
            r_instr_mem[r_wr_ptr] <= w_push_instr;
`ifdef FETCH_ACCESS_FAULT_EN
            r_fault_mem[r_wr_ptr] <= imem_resp_err;
`endif
        end else begin
            r_pc_mem[r_wr_ptr]    <= r_pc_mem[r_wr_ptr];
            r_instr_mem[r_wr_ptr] <= r_instr_mem[r_wr_ptr];
        end
    end

    // Head entry comes straight from registered storage; outputs are forced
    // to zero while the FIFO is empty.
    assign fetch_o_valid = (r_count != {CW{1'b0}});
    assign w_head_pc     = fetch_o_valid ? r_pc_mem[r_rd_ptr]    : {XLEN{1'b0}};
    assign w_head_instr  = fetch_o_valid ? r_instr_mem[r_rd_ptr] : {ILEN{1'b0}};

    assign fetch_o_bus_info    = {w_head_pc, w_head_instr};
    assign fetch_o_commit_info = fetch_o_valid ?
                                 {1'b1, w_head_instr, w_head_pc + PC_STEP, w_head_pc} :
                                 {(ILEN + 2*XLEN + 1){1'b0}};

`ifdef FETCH_ACCESS_FAULT_EN
    assign fetch_o_fault = fetch_o_valid && r_fault_mem[r_rd_ptr];
`else
    assign fetch_o_fault = 1'b0;
`endif

endmodule
